// File: rtl/ramwb_resp_if.sv
// Wishbone response-path bundle between the CPU bus interface unit and the
// delayed SDRAM slave, as seen by the response buffer.
interface ramwb_resp_if #(
    parameter int DATA_W = 32
);
    logic              biu_cyc_i;
    logic              biu_stb_i;
    logic              biu_we_i;
    logic [2:0]        biu_cti_i;
    logic              mem_ack_i;
    logic              mem_err_i;
    logic [DATA_W-1:0] mem_dat_i;
    logic              biu_ack_o;
    logic              biu_err_o;
    logic [DATA_W-1:0] biu_dat_o;

    modport slave (
        input  biu_cyc_i, biu_stb_i, biu_we_i, biu_cti_i,
        input  mem_ack_i, mem_err_i, mem_dat_i,
        output biu_ack_o, biu_err_o, biu_dat_o
    );

    modport master (
        output biu_cyc_i, biu_stb_i, biu_we_i, biu_cti_i,
        output mem_ack_i, mem_err_i, mem_dat_i,
        input  biu_ack_o, biu_err_o, biu_dat_o
    );
endinterface

// File: rtl/ramwb_resp_buffer.sv
// Collects a whole memory response (one word or a cache-line burst) into a FIFO,
// then replays it to the CPU with Wishbone-correct ack/err timing.
module ramwb_resp_buffer #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ci,
    ramwb_resp_if.slave      bus,
    output logic             busy_o,
    output logic             overflow_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        REPLAY  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  beats_exp_q, beats_exp_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              err_pend_q, err_pend_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic              overflow_q, overflow_d;

    logic [DATA_W-1:0] fifo_mem [DEPTH];
    logic              push;
    logic              req;
    logic              burst;
    logic [DATA_W-1:0] head;

    assign req   = bus.biu_cyc_i & bus.biu_stb_i;
    assign burst = (bus.biu_cti_i == 3'b010) || (bus.biu_cti_i == 3'b111);
    assign head  = fifo_mem[rd_ptr_q];

    always_comb begin
        state_d     = state_q;
        beats_exp_d = beats_exp_q;
        beat_cnt_d  = beat_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        err_pend_d  = err_pend_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        dat_d       = dat_q;
        overflow_d  = overflow_q;
        push        = 1'b0;

        if (!en) begin
            // Bypass mode: buffer parked empty so re-enabling starts clean.
            state_d    = IDLE;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            beat_cnt_d = '0;
            err_pend_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.mem_ack_i) begin
                        overflow_d = 1'b1;
                    end
                    if (req) begin
                        state_d     = COLLECT;
                        beats_exp_d = (ci | bus.biu_we_i) ? CNT_ONE : CNT_DEPTH;
                        beat_cnt_d  = '0;
                        wr_ptr_d    = '0;
                        rd_ptr_d    = '0;
                        count_d     = '0;
                        err_pend_d  = 1'b0;
                    end
                end

                COLLECT: begin
                    if (!bus.biu_cyc_i) begin
                        state_d    = IDLE;
                        wr_ptr_d   = '0;
                        rd_ptr_d   = '0;
                        count_d    = '0;
                        err_pend_d = 1'b0;
                    end else if (bus.mem_err_i) begin
                        // An error poisons the whole line; nothing buffered is replayed.
                        state_d    = REPLAY;
                        err_pend_d = 1'b1;
                        wr_ptr_d   = '0;
                        rd_ptr_d   = '0;
                        count_d    = '0;
                    end else if (bus.mem_ack_i) begin
                        if (beat_cnt_q < beats_exp_q) begin
                            push       = 1'b1;
                            wr_ptr_d   = wr_ptr_q + PTR_ONE;
                            count_d    = count_q + CNT_ONE;
                            beat_cnt_d = beat_cnt_q + CNT_ONE;
                            if ((beat_cnt_q + CNT_ONE) == beats_exp_q) begin
                                state_d = REPLAY;
                            end
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                end

                REPLAY: begin
                    if (bus.mem_ack_i) begin
                        overflow_d = 1'b1;
                    end
                    if (!bus.biu_cyc_i) begin
                        state_d    = IDLE;
                        wr_ptr_d   = '0;
                        rd_ptr_d   = '0;
                        count_d    = '0;
                        err_pend_d = 1'b0;
                    end else if (err_pend_q) begin
                        if (req) begin
                            err_d      = 1'b1;
                            err_pend_d = 1'b0;
                            state_d    = IDLE;
                        end
                    end else if (count_q == '0) begin
                        state_d = IDLE;
                    end else if (req && (burst || !ack_q)) begin
                        // Classic masters need one dead cycle to drop stb after an ack.
                        ack_d    = 1'b1;
                        dat_d    = head;
                        rd_ptr_d = rd_ptr_q + PTR_ONE;
                        count_d  = count_q - CNT_ONE;
                        if (count_q == CNT_ONE) begin
                            state_d = IDLE;
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beats_exp_q <= '0;
            beat_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            err_pend_q  <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            dat_q       <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            beats_exp_q <= beats_exp_d;
            beat_cnt_q  <= beat_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            err_pend_q  <= err_pend_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            dat_q       <= dat_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage carries no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= bus.mem_dat_i;
        end
    end

    assign bus.biu_ack_o = en ? ack_q : bus.mem_ack_i;
    assign bus.biu_err_o = en ? err_q : bus.mem_err_i;
    assign bus.biu_dat_o = en ? dat_q : bus.mem_dat_i;
    assign busy_o        = (state_q != IDLE);
    assign overflow_o    = overflow_q;
endmodule
